axi4_lite_wr_fifo_master: RTL

- Downstream consumer of the AXI4-lite write-FIFO bundle. Pops one address word from the AW FIFO and one data word from the W FIFO, then issues a single AXI4-lite write on its master port.
- Captures BRESP and pushes it into the B FIFO.
- Sits between the clock-domain/buffering FIFOs and the AXI4-lite interconnect. One outstanding transaction at a time.

---
 rtl/axi4_lite_pkg.sv | 26 ++
 rtl/axi4_lite_wr_chan_hs.sv | 34 +++
 rtl/axi4_lite_wr_fifo_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite definitions for the write-FIFO master.
//   axi4_lite_cfg_t      : A = address width, N = data bytes,
//                          USE_STRB = 0 forces write strobes all-ones
//   AXI4_LITE_RESP_*     : BRESP encodings
//   axi4_lite_wr_state_t : write master FSM states
package axi4_lite_pkg;

    typedef struct packed {
        int A;
        int N;
        int USE_STRB;
    } axi4_lite_cfg_t;

    localparam logic [1:0] AXI4_LITE_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_LITE_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_LITE_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_LITE_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        PUSH = 2'd3
    } axi4_lite_wr_state_t;

endpackage

// File: rtl/axi4_lite_wr_chan_hs.sv
// Per-channel valid/done tracker for one AXI4-lite request channel.
//   clk, rst : clock, synchronous active-high reset
//   start    : launch a new beat (valid rises next cycle)
//   ready    : channel ready from the slave
//   valid    : registered channel valid
//   done     : beat has completed, including a handshake in this cycle
module axi4_lite_wr_chan_hs (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ready,
    output logic valid,
    output logic done
);

    logic done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            valid  <= 1'b1;
            done_q <= 1'b0;
        end else if (valid && ready) begin
            valid  <= 1'b0;
            done_q <= 1'b1;
        end
    end

    // Look-ahead so the FSM can leave ADDR on the cycle of the final handshake.
    assign done = done_q | (valid & ready);

endmodule

// File: rtl/axi4_lite_wr_fifo_master.sv
// AXI4-lite write master fed by show-ahead AW/W FIFOs, returning BRESP
// into a B FIFO. One outstanding transaction at a time.
//   aclk, areset         : clock, synchronous active-high reset
//   aw_* / w_*           : AW and W FIFO read side (empty, pop, head)
//   b_wr_full/en, b_resp : B FIFO write side
//   aw*/w*/b*            : AXI4-lite master write channels
//   busy                 : high whenever the FSM is not IDLE
// Optional macro AXI4_LITE_WR_BRESP_ERR_EN adds err_sticky and err_count
// (saturating count of non-OKAY responses).
module axi4_lite_wr_fifo_master
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t C = '{default: 0}
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               aw_rd_empty,
    output logic               aw_rd_en,
    input  logic [C.A-1:0]     aw_addr,
    input  logic               w_rd_empty,
    output logic               w_rd_en,
    input  logic [8*C.N-1:0]   w_data,
    input  logic [C.N-1:0]     w_strb,
    input  logic               b_wr_full,
    output logic               b_wr_en,
    output logic [1:0]         b_resp,
    output logic [C.A-1:0]     awaddr,
    output logic [2:0]         awprot,
    output logic               awvalid,
    input  logic               awready,
    output logic [8*C.N-1:0]   wdata,
    output logic [C.N-1:0]     wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic               busy
`ifdef AXI4_LITE_WR_BRESP_ERR_EN
    ,
    output logic               err_sticky,
    output logic [7:0]         err_count
`endif
);

    axi4_lite_wr_state_t state, state_next;
    logic aw_done, w_done;
    logic b_capture;

    axi4_lite_wr_chan_hs u_aw_hs (
        .clk   (aclk),
        .rst   (areset),
        .start (aw_rd_en),
        .ready (awready),
        .valid (awvalid),
        .done  (aw_done)
    );

    axi4_lite_wr_chan_hs u_w_hs (
        .clk   (aclk),
        .rst   (areset),
        .start (w_rd_en),
        .ready (wready),
        .valid (wvalid),
        .done  (w_done)
    );

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        aw_rd_en   = 1'b0;
        w_rd_en    = 1'b0;
        bready     = 1'b0;
        b_wr_en    = 1'b0;
        b_capture  = 1'b0;
        case (state)
            IDLE: begin
                // Both heads must be present; popping only one would split a write.
                if (!aw_rd_empty && !w_rd_empty) begin
                    aw_rd_en   = 1'b1;
                    w_rd_en    = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (aw_done && w_done) state_next = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    b_capture  = 1'b1;
                    state_next = PUSH;
                end
            end
            PUSH: begin
                if (!b_wr_full) begin
                    b_wr_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request payload loads only at pop time, so it holds while valids are high.
    always_ff @(posedge aclk) begin
        if (areset) begin
            awaddr <= '0;
            wdata  <= '0;
            wstrb  <= '0;
            b_resp <= 2'b00;
        end else begin
            if (aw_rd_en) begin
                awaddr <= aw_addr;
                wdata  <= w_data;
                wstrb  <= (C.USE_STRB != 0) ? w_strb : '1;
            end
            if (b_capture) b_resp <= bresp;
        end
    end

    assign awprot = 3'b000;
    assign busy   = (state != IDLE);

`ifdef AXI4_LITE_WR_BRESP_ERR_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else if (b_capture && (bresp != AXI4_LITE_RESP_OKAY)) begin
            err_sticky <= 1'b1;
            err_count  <= sat_inc8(err_count);
        end
    end
`endif

endmodule
